sensor_sequencer: RTL

SENSOR_SEQUENCER -- requirements
Module: sensor_sequencer

---
 rtl/sensor_pkg.sv | 31 +++
 rtl/sensor_sequencer_counter.sv | 30 +++
 rtl/sensor_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// sensor_pkg: shared definitions for the sensor sequencer.
//   state_e          - sequencer FSM states
//   DEFAULT_*        - default timing constants
//   phase_cnt_width  - width of the shared phase counter
package sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } state_e;

  localparam int DEFAULT_ERASE_TIME    = 5;
  localparam int DEFAULT_ROW_READ_TIME = 5;
  localparam int DEFAULT_ADC_BITS      = 8;

  // Wide enough for the longest exposure, the full ramp (2^adc_bits) and
  // the whole read window.
  function automatic int phase_cnt_width(input int expose_bits,
                                         input int adc_bits,
                                         input int read_len);
    int w;
    w = expose_bits;
    if (adc_bits + 1 > w) w = adc_bits + 1;
    if ($clog2(read_len) + 1 > w) w = $clog2(read_len) + 1;
    return w;
  endfunction

endpackage

// File: rtl/sensor_sequencer_counter.sv
// sensor_sequencer_counter: generic up-counter with synchronous clear.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr_i       - synchronous clear (wins over en_i)
//   en_i        - increment enable
//   count_o     - registered count value
module sensor_sequencer_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sensor_sequencer.sv
// sensor_sequencer: frame sequencer for a pixel array
// (ERASE -> EXPOSE -> CONVERT -> READ).
//   clk, reset        - clock, asynchronous active-low reset
//   start             - frame request, honoured only in IDLE
//   continuous        - chain the next frame straight after READ
//   abort             - synchronous cancel of the running frame
//   expose_time       - exposure length, latched on accepted start
//   p_erase/p_expose/p_convert - phase enables (levels, not clocks)
//   p_row_select      - one-hot row select during READ
//   p_dRamp           - digital ADC ramp
//   row_valid         - pulse on the last cycle of each selected row
//   busy              - high outside IDLE
//   frame_done        - pulse on the last READ cycle
//   dbg_state_o       - current FSM state
// row_valid and frame_done are single-cycle qualifiers with no back-pressure:
// the consumer must take the row data in the cycle the pulse is high.
module sensor_sequencer
  import sensor_pkg::*;
#(
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int ADC_BITS           = DEFAULT_ADC_BITS,
  parameter int ERASE_TIME         = DEFAULT_ERASE_TIME,
  parameter int ROW_READ_TIME      = DEFAULT_ROW_READ_TIME,
  parameter int EXPOSE_BITS        = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          continuous,
  input  logic                          abort,
  input  logic [EXPOSE_BITS-1:0]        expose_time,
  output logic                          p_erase,
  output logic                          p_expose,
  output logic                          p_convert,
  output logic [PIXEL_ARRAY_HEIGHT-1:0] p_row_select,
  output logic [ADC_BITS-1:0]           p_dRamp,
  output logic                          row_valid,
  output logic                          busy,
  output logic                          frame_done,
  output state_e                        dbg_state_o
);

  localparam int READ_LEN = ROW_READ_TIME * PIXEL_ARRAY_HEIGHT;
  localparam int CW       = phase_cnt_width(EXPOSE_BITS, ADC_BITS, READ_LEN);
  localparam int RTW      = (ROW_READ_TIME > 1) ? $clog2(ROW_READ_TIME) : 1;

  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q;
  logic                          cnt_clr;
  logic                          ramp_clr, ramp_en;
  logic [EXPOSE_BITS-1:0]        exp_q, exp_d, exp_eff;
  logic [RTW-1:0]                row_tick_q, row_tick_d;
  logic [PIXEL_ARRAY_HEIGHT-1:0] row_q, row_d;
  logic                          row_valid_d, frame_done_d;
  logic                          phase_end;
  logic                          erase_q, expose_q, convert_q;
  logic                          row_valid_q, busy_q, frame_done_q;

  // Phase counter: cycles spent in the current state (0 on the first cycle).
  sensor_sequencer_counter #(.W(CW)) u_phase_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (cnt_clr),
    .en_i   (1'b1),
    .count_o(cnt_q)
  );

  // Ramp counter: only advances while staying in CONVERT, so it holds its
  // final value through READ.
  sensor_sequencer_counter #(.W(ADC_BITS)) u_ramp_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (ramp_clr),
    .en_i   (ramp_en),
    .count_o(p_dRamp)
  );

  always_comb begin
    // An exposure of 0 is stretched to one cycle.
    exp_eff   = (exp_q == '0) ? EXPOSE_BITS'(1) : exp_q;
    phase_end = 1'b0;
    unique case (state_q)
      ST_ERASE:   phase_end = (cnt_q == CW'(ERASE_TIME - 1));
      ST_EXPOSE:  phase_end = (cnt_q == CW'(exp_eff) - CW'(1));
      ST_CONVERT: phase_end = (cnt_q == CW'((1 << ADC_BITS) - 1));
      ST_READ:    phase_end = (cnt_q == CW'(READ_LEN - 1));
      default:    phase_end = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    if (state_q == ST_IDLE) begin
      // abort together with start in IDLE cancels the request.
      if (start && !abort) begin
        state_d = ST_ERASE;
        exp_d   = expose_time;
      end
    end else if (abort) begin
      state_d = ST_IDLE;
    end else if (phase_end) begin
      unique case (state_q)
        ST_ERASE:   state_d = ST_EXPOSE;
        ST_EXPOSE:  state_d = ST_CONVERT;
        ST_CONVERT: state_d = ST_READ;
        ST_READ: begin
          if (continuous) begin
            state_d = ST_ERASE;
            exp_d   = expose_time;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign cnt_clr  = (state_d != state_q) || (state_q == ST_IDLE);
  assign ramp_clr = (state_d == ST_ERASE) || (state_d == ST_IDLE);
  assign ramp_en  = (state_q == ST_CONVERT) && (state_d == ST_CONVERT);

  // Row shifter: bit 0 on READ entry, shift left after each full row.
  // READ ends exactly on the last row's final cycle, so it never wraps.
  always_comb begin
    row_tick_d = '0;
    row_d      = '0;
    if (state_d == ST_READ) begin
      if (state_q == ST_READ) begin
        if (row_tick_q == RTW'(ROW_READ_TIME - 1)) begin
          row_d = row_q << 1;
        end else begin
          row_tick_d = row_tick_q + RTW'(1);
          row_d      = row_q;
        end
      end else begin
        row_d[0] = 1'b1;
      end
    end
    row_valid_d  = (state_d == ST_READ) && (row_tick_d == RTW'(ROW_READ_TIME - 1));
    frame_done_d = row_valid_d && row_d[PIXEL_ARRAY_HEIGHT-1];
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      exp_q        <= '0;
      row_tick_q   <= '0;
      row_q        <= '0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      row_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      row_tick_q   <= row_tick_d;
      row_q        <= row_d;
      erase_q      <= (state_d == ST_ERASE);
      expose_q     <= (state_d == ST_EXPOSE);
      convert_q    <= (state_d == ST_CONVERT);
      row_valid_q  <= row_valid_d;
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= frame_done_d;
    end
  end

  assign p_erase      = erase_q;
  assign p_expose     = expose_q;
  assign p_convert    = convert_q;
  assign p_row_select = row_q;
  assign row_valid    = row_valid_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign dbg_state_o  = state_q;

endmodule
